// File: rtl/xbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xbuf_pkg
//  Description : Shared geometry, counter widths and FSM state encoding for
//                the X buffer load/shift controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package xbuf_pkg;

    localparam int DATA_W       = 8;
    localparam int N_ROWS       = 4;
    localparam int N_COLS       = 8;
    localparam int LOAD_LEN     = N_ROWS * N_COLS;
    localparam int SHIFT_CYCLES = 8;

    localparam int CNT_W        = $clog2(LOAD_LEN);
    localparam int SIDX_W       = $clog2(SHIFT_CYCLES);

    // Controller state encoding (legacy-compatible plain constants)
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_drain = 3'd2;
    localparam logic [2:0] c_st_shift = 3'd3;
    localparam logic [2:0] c_st_fin   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/x_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : x_load_ctrl_if
//  Description : Stream-in / X-buffer-out bundle of the X load controller.
//                master = controller view, slave = source/buffer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface x_load_ctrl_if;
    import xbuf_pkg::*;

    logic                  start;
    logic                  abort;
    logic [DATA_W-1:0]     in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     X_load;
    logic                  valid_input;
    logic                  input_load_en;
    logic                  xload_done;
    logic                  X_shift;
    logic [SIDX_W-1:0]     shift_idx;
    logic                  busy;
    logic                  done;
    logic                  load_err;

    modport master (
        input  start, abort, in_data, in_valid, xload_done,
        output in_ready, X_load, valid_input, input_load_en,
               X_shift, shift_idx, busy, done, load_err
    );

    modport slave (
        output start, abort, in_data, in_valid, xload_done,
        input  in_ready, X_load, valid_input, input_load_en,
               X_shift, shift_idx, busy, done, load_err
    );

endinterface
`default_nettype wire

// File: rtl/x_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : x_load_ctrl
//  Description : Writer side of the X buffer. Accepts LOAD_LEN bytes over a
//                valid/ready stream, replays them as registered X_load /
//                valid_input strobes, then issues SHIFT_CYCLES X_shift pulses
//                and a one-cycle done. Cross-checks the buffer's xload_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module x_load_ctrl
    import xbuf_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    x_load_ctrl_if.master   bus
);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_pidx;
    logic [SIDX_W-1:0]   r_sidx;
    logic [DATA_W-1:0]   r_xload;
    logic                r_valid;
    logic                r_load_err;

    logic                w_fire;
    logic                w_last_byte;
    logic                w_last_shift;
    logic                w_xchk_err;

    // in_ready is a pure decode of LOAD, so fire needs only in_valid there
    assign w_fire       = bus.in_valid && (r_state == c_st_load);
    assign w_last_byte  = (r_cnt  == CNT_W'(LOAD_LEN - 1));
    assign w_last_shift = (r_sidx == SIDX_W'(SHIFT_CYCLES - 1));

    // The buffer must flag "done" on, and only on, the last presented byte
    assign w_xchk_err   = r_valid &&
                          (bus.xload_done != (r_pidx == CNT_W'(LOAD_LEN - 1)));

    // Next-state decode; abort overrides everything including start
    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (bus.start) w_state_nxt = c_st_load;
                c_st_load:  if (w_fire && w_last_byte) w_state_nxt = c_st_drain;
                c_st_drain: w_state_nxt = c_st_shift;
                c_st_shift: if (w_last_shift) w_state_nxt = c_st_fin;
                c_st_fin:   w_state_nxt = c_st_idle;
                default:    w_state_nxt = c_st_idle;
            endcase
        end
    end

    // State, byte/shift counters, replay register and sticky cross-check flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_pidx     <= '0;
            r_sidx     <= '0;
            r_xload    <= '0;
            r_valid    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_fire && !bus.abort;

            if (w_fire && !bus.abort) begin
                r_xload <= bus.in_data;
                r_pidx  <= r_cnt;
            end

            // Byte counter only moves in LOAD; the 31->0 wrap coincides with DRAIN
            if (bus.abort || (r_state == c_st_idle)) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (bus.abort || (r_state != c_st_shift) || w_last_shift) begin
                r_sidx <= '0;
            end else begin
                r_sidx <= r_sidx + SIDX_W'(1);
            end

            if (w_xchk_err) begin
                r_load_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready      = (r_state == c_st_load);
    assign bus.input_load_en = (r_state == c_st_load) || (r_state == c_st_drain);
    assign bus.X_shift       = (r_state == c_st_shift);
    assign bus.shift_idx     = r_sidx;
    assign bus.done          = (r_state == c_st_fin);
    assign bus.busy          = (r_state != c_st_idle);
    assign bus.X_load        = r_xload;
    assign bus.valid_input   = r_valid;
    assign bus.load_err      = r_load_err;

endmodule
`default_nettype wire
